// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: FSM encodings and defaults.
package looper_defs;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  localparam int unsigned DEF_MEM_LAT = 3;

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin picker: the search starts one past last_gnt_i.
module rr_pick #(
  parameter  int unsigned N_REQ = 2,
  localparam int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] last_gnt_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic             any_req_o
);

  int unsigned      idx;
  logic [IDX_W-1:0] sel;
  logic             found;

  assign any_req_o = |req_i;

  // Walk the requesters in rotating order and keep the first one asking.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = 0;
    sel   = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = (32'(last_gnt_i) + k) % N_REQ;
      sel = IDX_W'(idx);
      if (!found && req_i[sel]) begin
        gnt_o[sel] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin sequencer sharing one fixed-latency, single-ported memory
// between N_REQ requesters; one access per grant, done pulse on completion.
module mem_port_arbiter
  import looper_defs::*;
#(
  parameter int unsigned N_REQ   = 2,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned MEM_LAT = DEF_MEM_LAT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          wr,
  input  logic [N_REQ*ADDR_W-1:0]   addr,
  input  logic [N_REQ*DATA_W-1:0]   wdata,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          done,
  output logic [DATA_W-1:0]         rdata,
  output logic                      mem_en,
  output logic                      mem_wr,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata
);

  localparam int unsigned      IDX_W    = $clog2(N_REQ);
  localparam int unsigned      CNT_W    = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MEM_LAT);

  arb_state_e        state_q, state_d;
  // last_gnt doubles as the latched winner: it is written on every ISSUE entry
  // and only read as the owner while a transaction is in flight.
  logic [IDX_W-1:0]  last_q, last_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [N_REQ-1:0]  pick_mask, pick_oh;
  logic [IDX_W-1:0]  pick_idx;
  logic              any_pick;
  logic              issue_go;

  // In RESP the current owner is masked so another requester can go back-to-back.
  assign pick_mask = req & ~gnt;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req_i      (pick_mask),
    .last_gnt_i (last_q),
    .gnt_o      (pick_oh),
    .any_req_o  (any_pick)
  );

  // Encode the one-hot pick into an index.
  always_comb begin
    pick_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (pick_oh[i]) pick_idx = IDX_W'(i);
    end
  end

  // Next-state, latency counter and request latching.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    issue_go = 1'b0;
    case (state_q)
      IDLE:  if (any_pick) issue_go = 1'b1;
      ISSUE: begin
        if (MEM_LAT == 1) state_d = RESP;
        else              state_d = WAIT;
      end
      WAIT:  if (cnt_q == CNT_LAST) state_d = RESP;
      RESP: begin
        if (any_pick) issue_go = 1'b1;
        else          state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if ((state_q == ISSUE || state_q == WAIT) && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (issue_go) begin
      state_d = ISSUE;
      last_d  = pick_idx;
      wr_d    = wr[pick_idx];
      addr_d  = addr[pick_idx*ADDR_W +: ADDR_W];
      wdata_d = wdata[pick_idx*DATA_W +: DATA_W];
      cnt_d   = '0;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= IDX_W'(N_REQ - 1);
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decoded from state; everything is zero while idle.
  always_comb begin
    gnt       = '0;
    done      = '0;
    rdata     = '0;
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q != IDLE) begin
      gnt[last_q] = 1'b1;
      mem_wr      = wr_q;
      mem_addr    = addr_q;
      mem_wdata   = wdata_q;
    end
    if (state_q == ISSUE) mem_en = 1'b1;
    if (state_q == RESP) begin
      done[last_q] = 1'b1;
      if (!wr_q) rdata = mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter (MEM_LAT=3 main instance, MEM_LAT=1 side instance).
module tb_mem_port_arbiter;

  localparam int LAT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  req, wr, gnt, done;
  logic [31:0] addr, wdata;
  logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_en, mem_wr;

  logic [1:0]  req_b, wr_b, gnt_b, done_b;
  logic [31:0] addr_b, wdata_b;
  logic [15:0] rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;
  logic        mem_en_b, mem_wr_b;

  mem_port_arbiter #(.N_REQ(2), .ADDR_W(16), .DATA_W(16), .MEM_LAT(3)) dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
    .gnt(gnt), .done(done), .rdata(rdata), .mem_en(mem_en), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.N_REQ(2), .ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .wr(wr_b), .addr(addr_b), .wdata(wdata_b),
    .gnt(gnt_b), .done(done_b), .rdata(rdata_b), .mem_en(mem_en_b), .mem_wr(mem_wr_b),
    .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b)
  );

  function automatic logic [15:0] mem_model(input logic [15:0] a);
    return a ^ 16'hBEAF;
  endfunction

  // Memory models: data valid exactly LAT cycles after the mem_en cycle, junk otherwise.
  logic [LAT-1:0] vp = '0;
  logic [15:0]    ap [LAT];
  always @(posedge clk) begin
    vp    <= {vp[LAT-2:0], mem_en};
    ap[0] <= mem_addr;
    for (int i = 1; i < LAT; i++) ap[i] <= ap[i-1];
  end
  assign mem_rdata = vp[LAT-1] ? mem_model(ap[LAT-1]) : 16'hDEAD;

  logic        vb = 1'b0;
  logic [15:0] ab;
  always @(posedge clk) begin
    vb <= mem_en_b;
    ab <= mem_addr_b;
  end
  assign mem_rdata_b = vb ? mem_model(ab) : 16'hDEAD;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  typedef struct {
    int          id;
    logic        w;
    logic [15:0] a;
    logic [15:0] d;
    int          at;
    int          gap;
  } txn_t;

  txn_t exp_q[$];
  txn_t cur;
  logic pend = 1'b0;
  logic early_drop = 1'b0;
  int   last_issue = 0;
  int   cyc = 0;
  int   rem[2] = '{0, 0};

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor for the main instance.
  always @(negedge clk) begin
    logic [1:0] oh;
    logic       resp;
    txn_t       e;
    if (rst) begin
      pend = 1'b0;
    end else begin
      if (mem_en) begin
        if (pend) check_eq("issue_while_busy", 64'(mem_en), 64'(0));
        else if (exp_q.size() == 0) check_eq("spurious_issue", 64'(mem_en), 64'(0));
        else begin
          e = exp_q.pop_front();
          if (e.at >= 0) check_eq("issue_cycle", 64'(cyc), 64'(e.at));
          if (e.gap > 0) check_eq("issue_gap", 64'(cyc - last_issue), 64'(e.gap));
          cur        = e;
          pend       = 1'b1;
          last_issue = cyc;
        end
      end
      oh   = pend ? (2'b01 << cur.id) : 2'b00;
      resp = pend && (cyc == last_issue + LAT);
      check_eq("gnt", 64'(gnt), 64'(oh));
      check_eq("mem_bus", 64'({mem_wr, mem_addr, mem_wdata}),
               pend ? 64'({cur.w, cur.a, cur.d}) : 64'(0));
      check_eq("done", 64'(done), resp ? 64'(oh) : 64'(0));
      check_eq("rdata", 64'(rdata), (resp && !cur.w) ? 64'(mem_model(cur.a)) : 64'(0));
      if (resp) pend = 1'b0;
    end
  end

  task automatic push(input int id, input logic w, input logic [15:0] a, input logic [15:0] d,
                      input int at, input int gap);
    txn_t t;
    t.id = id; t.w = w; t.a = a; t.d = d; t.at = at; t.gap = gap;
    exp_q.push_back(t);
    rem[id]++;
  endtask

  task automatic drive(input int id, input logic w, input logic [15:0] a, input logic [15:0] d);
    wr[id]             = w;
    addr[id*16 +: 16]  = a;
    wdata[id*16 +: 16] = d;
    req[id]            = 1'b1;
  endtask

  // Requesters drop req on seeing their last done; bounded wait for the queue to drain.
  task automatic run(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || pend) && n < budget) begin
      @(negedge clk);
      n++;
      for (int i = 0; i < 2; i++) begin
        if (done[i]) begin
          rem[i]--;
          if (rem[i] <= 0) req[i] = 1'b0;
        end
      end
      if (early_drop && mem_en) req[1] = 1'b0;
    end
    if (n >= budget) begin
      check_eq("timeout", 64'(exp_q.size()) + 64'(pend), 64'(0));
      exp_q.delete();
      req = '0;
    end
  endtask

  // Start a read, then assert reset asynchronously while it sits in WAIT.
  task automatic reset_in_wait(input int id, input logic [15:0] a);
    @(posedge clk); #1;
    push(id, 1'b0, a, 16'h0000, cyc + 1, 0);
    drive(id, 1'b0, a, 16'h0000);
    @(posedge clk);
    @(posedge clk); #2;
    check_eq("pre_rst_gnt", 64'(gnt), 64'(2'b01 << id));
    rst = 1'b1;
    #1;
    check_eq("rst_async_outs",
             64'({gnt, done, rdata, mem_en, mem_wr, mem_addr, mem_wdata}), 64'(0));
    req     = '0;
    rem[id] = 0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req = '0; wr = '0; addr = '0; wdata = '0;
    req_b = '0; wr_b = '0; addr_b = '0; wdata_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_outs", 64'({gnt, done, rdata, mem_en, mem_wr, mem_addr, mem_wdata}), 64'(0));
    rst = 1'b0;

    // Single read by requester 0.
    @(posedge clk); #1;
    push(0, 1'b0, 16'h0040, 16'h0000, cyc + 1, 0);
    drive(0, 1'b0, 16'h0040, 16'h0000);
    run(40);

    // Requester 1 write, req dropped right after ISSUE.
    @(posedge clk); #1;
    early_drop = 1'b1;
    push(1, 1'b1, 16'h0030, 16'h5555, cyc + 1, 0);
    drive(1, 1'b1, 16'h0030, 16'h5555);
    run(40);
    early_drop = 1'b0;

    // Continuous contention: 0,1,0,1 back-to-back.
    @(posedge clk); #1;
    push(0, 1'b1, 16'h0010, 16'h1234, cyc + 1, 0);
    push(1, 1'b0, 16'h0020, 16'hAAAA, -1, 4);
    push(0, 1'b1, 16'h0010, 16'h1234, -1, 4);
    push(1, 1'b0, 16'h0020, 16'hAAAA, -1, 4);
    drive(0, 1'b1, 16'h0010, 16'h1234);
    drive(1, 1'b0, 16'h0020, 16'hAAAA);
    run(80);

    // Requester 0 holds req through its done: one IDLE cycle before re-issue.
    @(posedge clk); #1;
    push(0, 1'b0, 16'h0050, 16'h0000, cyc + 1, 0);
    push(0, 1'b0, 16'h0050, 16'h0000, -1, LAT + 2);
    drive(0, 1'b0, 16'h0050, 16'h0000);
    run(60);

    // Reset in WAIT, then both requesting: requester 0 wins first.
    reset_in_wait(0, 16'h0100);
    @(posedge clk); #1;
    push(0, 1'b0, 16'h0200, 16'h0000, cyc + 1, 0);
    push(1, 1'b1, 16'h0300, 16'h7777, -1, 4);
    drive(0, 1'b0, 16'h0200, 16'h0000);
    drive(1, 1'b1, 16'h0300, 16'h7777);
    run(60);

    // Reset in WAIT, then only requester 1 requesting.
    reset_in_wait(0, 16'h0600);
    @(posedge clk); #1;
    push(1, 1'b0, 16'h0700, 16'h0000, cyc + 1, 0);
    drive(1, 1'b0, 16'h0700, 16'h0000);
    run(40);

    // MEM_LAT=1 instance: ISSUE and RESP in consecutive cycles.
    @(posedge clk); #1;
    req_b = 2'b01; wr_b = 2'b00; addr_b[15:0] = 16'h0077; wdata_b = '0;
    @(negedge clk);
    check_eq("l1_idle", 64'({gnt_b, mem_en_b, done_b}), 64'(0));
    @(negedge clk);
    check_eq("l1_issue", 64'({gnt_b, mem_en_b, done_b, mem_addr_b}),
             64'({2'b01, 1'b1, 2'b00, 16'h0077}));
    @(negedge clk);
    check_eq("l1_resp", 64'({gnt_b, mem_en_b, done_b, rdata_b}),
             64'({2'b01, 1'b0, 2'b01, mem_model(16'h0077)}));
    req_b = 2'b00;
    @(negedge clk);
    check_eq("l1_after", 64'({gnt_b, mem_en_b, done_b, rdata_b}), 64'(0));

    repeat (6) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Round-robin arbiter and sequencer that shares one single-ported, fixed-latency memory between N_REQ requesters, such as instruction fetch and data load/store. It accepts level requests, selects one winner, and issues exactly one memory access for it. It counts out the memory latency, returns a one-cycle done pulse with read data to the winner, and then re-arbitrates. All control state lives in flip-flops with asynchronous clear.

## Interface
Parameters
- N_REQ, 2: number of requesters (≥2).
- ADDR_W, 16: address width.
- DATA_W, 16: data width.
- MEM_LAT, 3: cycles from the mem_en cycle to valid mem_rdata (≥1).

Ports
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset; clears all state immediately.
- req  in  N_REQ  per-requester request level.
- wr  in  N_REQ  per-requester access type: 1 = write, 0 = read.
- addr  in  N_REQ*ADDR_W  per-requester address, packed; slice i belongs to requester i.
- wdata  in  N_REQ*DATA_W  per-requester write data, packed.
- gnt  out  N_REQ  one-hot; marks the requester that owns the memory.
- done  out  N_REQ  one-hot, one-cycle pulse marking transaction completion.
- rdata  out  DATA_W  read data; valid only while done is asserted for a read.
- mem_en  out  1  one-cycle access strobe to the memory.
- mem_wr  out  1  access type for the memory.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid MEM_LAT cycles after mem_en.

## Operation
- FSM states:
  - IDLE: no transaction in progress.
  - ISSUE: mem_en=1 for exactly one cycle.
  - WAIT: latency counter runs.
  - RESP: done pulse.
- Transitions:
  - IDLE→ISSUE when any req=1 at the clock edge; otherwise stay in IDLE.
  - ISSUE→WAIT if MEM_LAT>1.
  - ISSUE→RESP if MEM_LAT=1.
  - WAIT→RESP when the counter reaches MEM_LAT-1.
  - RESP→ISSUE (back-to-back) if any other requester is requesting; otherwise RESP→IDLE.
- Arbitration:
  - Round-robin pointer last_gnt; the search starts at (last_gnt+1) mod N_REQ.
  - last_gnt resets to N_REQ-1, so requester 0 wins first.
  - last_gnt updates to the winner when ISSUE is entered.
  - In RESP, the current winner's req is masked out of arbitration, since a requester drops req only after seeing done.
- The winner index and its wr/addr/wdata are latched on entry to ISSUE. Requester inputs may change after that without effect.
- gnt[w]=1 from ISSUE through RESP inclusive; all zero in IDLE.
- mem_wr, mem_addr and mem_wdata come from the latched values and are held for the whole transaction. All three are zero in IDLE.
- RESP behaviour:
  - done[w]=1.
  - rdata=mem_rdata for a read.
  - rdata=0 for a write and in every cycle that is not a read RESP.
- If the winner drops req before done, the access still completes and done still pulses. The memory cannot abort.
- Latency counter width is clog2(MEM_LAT+1). The counter clears on ISSUE entry and saturates, never wrapping.
- Reset values: state=IDLE, gnt=0, done=0, rdata=0, mem_en=0, mem_wr=0, mem_addr=0, mem_wdata=0, counter=0, last_gnt=N_REQ-1.
- Reset mid-transaction abandons the access. No done is produced, and the first request after reset is arbitrated fresh.

## Timing
- req sampled high at edge of cycle t → ISSUE in cycle t+1 (gnt, mem_en high).
- Per-transaction cycle numbering:
  - ISSUE = cycle c.
  - mem_rdata is valid in cycle c+MEM_LAT.
  - RESP = cycle c+MEM_LAT.
- Service time is MEM_LAT+1 cycles per transaction.
- Back-to-back: the next ISSUE is in cycle c+MEM_LAT+1, with no idle cycle.
- Simultaneous requests are resolved purely by the round-robin pointer. With continuous contention, each requester is served once every N_REQ transactions.

## Structure
- Shared package looper_defs holds:
  - the FSM state encodings (IDLE, ISSUE, WAIT, RESP, 2 bits);
  - the default MEM_LAT.
- Sub-module rr_pick is a combinational round-robin picker.
  - Inputs: request mask and last_gnt.
  - Outputs: one-hot winner and any_req.
  - It is instantiated once.
- All registers use asynchronous clear on rst.

## Test plan
- Reset check: assert rst mid-run → all outputs 0 in the same cycle. Release rst, then req=2'b01, wr=0, addr0=16'h0040 → gnt=01 and mem_en=1 one cycle later, mem_addr=16'h0040. With mem_rdata=16'hBEEF, done=01 and rdata=16'hBEEF 3 cycles after ISSUE.
- Contention: req=2'b11 held, requester 0 write addr 16'h0010 wdata 16'h1234, requester 1 read addr 16'h0020 → ISSUE order 0,1,0,1. ISSUE cycles are 4 cycles apart, with no idle cycle between transactions.
- Early drop: requester 1 drops req the cycle after its ISSUE → its done[1] still pulses at ISSUE+3. rdata=0 because the access is a write.
- Masking in RESP: requester 0 holds req through its own done cycle while requester 1 is idle → FSM returns to IDLE. Requester 0 gets a new ISSUE only when its req is still high at the next edge.
- MEM_LAT=1 build: single read → ISSUE then RESP in consecutive cycles, with the WAIT state never entered.
- Reset during WAIT: rst pulse → no done is produced. A later req=2'b10 is granted to requester 1 first, because last_gnt reset to 1 makes requester 0 the first in search order only when it is requesting.
